// File: rtl/sound_request_sequencer.sv
// Sound request sequencer: queues buzzer sound codes and sequences the tone generator
// through restart, play and silent-gap phases for each queued melody.
module sound_request_sequencer #(
  parameter int unsigned STEP_CYCLES = 6_250_002,
  parameter int unsigned LEN_SEL     = 64,
  parameter int unsigned LEN_OTHER   = 48,
  parameter int unsigned GAP_CYCLES  = 1_000_000,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned DEPTH       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  input  logic [2:0] i_req_code,
  output logic       o_req_ready,
  output logic [2:0] o_sound_code,
  output logic       o_play_sound,
  output logic       o_snd_rstn,
  output logic       o_busy,
  output logic [7:0] o_flush_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] RstLast = 32'(RST_CYCLES - 1);
  localparam logic [31:0] SelLast = 32'(LEN_SEL * STEP_CYCLES - 1);
  localparam logic [31:0] OthLast = 32'(LEN_OTHER * STEP_CYCLES - 1);
  localparam logic [31:0] GapLast = 32'(GAP_CYCLES - 1);
  localparam logic [AW:0] PtrOne  = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StRestart, StPlay, StGap} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_cnt, w_cnt_d;
  logic [2:0]  r_code, w_code_d;
  logic [7:0]  r_flush, w_flush_d;
  logic        r_play, r_rstn, r_busy;
  logic [2:0]  r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr, w_wptr_d, w_rptr_d, w_occ;
  logic        w_full, w_empty, w_accept, w_push, w_pop, w_preempt;
  logic [8:0]  w_flush_sum;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty     = (r_wptr == r_rptr);
  assign w_occ       = r_wptr - r_rptr;
  assign o_req_ready = (i_req_code == 3'd7) || !w_full;
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_preempt   = w_accept && (i_req_code == 3'd7);
  assign w_push      = w_accept && (i_req_code != 3'd0) && (i_req_code != 3'd7);
  assign w_flush_sum = {1'b0, r_flush} + 9'(w_occ);

  assign o_sound_code = r_code;
  assign o_play_sound = r_play;
  assign o_snd_rstn   = r_rstn;
  assign o_busy       = r_busy;
  assign o_flush_cnt  = r_flush;

  // Next-state logic: phase sequencing, FIFO pointer updates and code-7 preemption.
  always_comb begin
    w_state_d = r_state;
    w_code_d  = r_code;
    w_cnt_d   = (r_cnt != 32'd0) ? r_cnt - 32'd1 : r_cnt;
    w_flush_d = r_flush;
    w_pop     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_code_d  = r_mem[r_rptr[AW-1:0]];
          w_state_d = StRestart;
          w_cnt_d   = RstLast;
        end
      end
      StRestart: begin
        if (r_cnt == 32'd0) begin
          w_state_d = StPlay;
          w_cnt_d   = (r_code == 3'd1) ? SelLast : OthLast;
        end
      end
      StPlay: begin
        if (r_cnt == 32'd0) begin
          w_state_d = StGap;
          w_cnt_d   = GapLast;
        end
      end
      StGap: begin
        if (r_cnt == 32'd0) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_wptr_d = w_push ? r_wptr + PtrOne : r_wptr;
    w_rptr_d = w_pop  ? r_rptr + PtrOne : r_rptr;

    // Preemption discards the queue and aborts whatever is playing.
    if (w_preempt) begin
      w_state_d = StRestart;
      w_code_d  = 3'd7;
      w_cnt_d   = RstLast;
      w_rptr_d  = r_wptr;
      w_flush_d = w_flush_sum[8] ? 8'hFF : w_flush_sum[7:0];
    end
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= 32'd0;
      r_code  <= 3'd0;
      r_flush <= 8'd0;
      r_play  <= 1'b0;
      r_rstn  <= 1'b0;
      r_busy  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_code  <= w_code_d;
      r_flush <= w_flush_d;
      r_play  <= (w_state_d == StPlay);
      r_rstn  <= (w_state_d != StRestart);
      r_busy  <= (w_state_d != StIdle) || (w_wptr_d != w_rptr_d);
      r_wptr  <= w_wptr_d;
      r_rptr  <= w_rptr_d;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_req_code;
    end
  end

endmodule

// File: tb/tb_sound_request_sequencer.sv
// Directed bench for sound_request_sequencer with a melody scoreboard.
module tb_sound_request_sequencer;

  localparam int Step = 4;
  localparam int LenSel = 64;
  localparam int LenOther = 48;

  logic       clk;
  logic       i_rst, i_req_valid;
  logic [2:0] i_req_code;
  logic       o_req_ready, o_play_sound, o_snd_rstn, o_busy;
  logic [2:0] o_sound_code;
  logic [7:0] o_flush_cnt;

  typedef struct {
    logic [2:0] code;
    int         len;  // 0: aborted melody, length not checked
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   m_flush = 0;

  sound_request_sequencer #(
    .STEP_CYCLES(Step),
    .LEN_SEL    (LenSel),
    .LEN_OTHER  (LenOther),
    .GAP_CYCLES (3),
    .RST_CYCLES (2),
    .DEPTH      (4)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .i_req_code  (i_req_code),
    .o_req_ready (o_req_ready),
    .o_sound_code(o_sound_code),
    .o_play_sound(o_play_sound),
    .o_snd_rstn  (o_snd_rstn),
    .o_busy      (o_busy),
    .o_flush_cnt (o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int len_of(input logic [2:0] c);
    return (c == 3'd1) ? LenSel * Step : LenOther * Step;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Watches play_sound pulses and scores each melody against the queue head.
  task automatic monitor();
    logic       prev = 1'b0;
    int         len = 0;
    int         unstable = 0;
    logic [2:0] code = 3'd0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (o_play_sound === 1'b1) begin
        if (!prev) begin
          len = 0;
          unstable = 0;
          code = o_sound_code;
        end
        len++;
        if (o_sound_code !== code) unstable++;
      end else if (prev) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL mon_unexpected observed=melody code %0d expected=none", code);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("mon_code", int'(code), int'(e.code));
          if (e.len != 0) chk("mon_len", len, e.len);
          chk("mon_code_stable", unstable, 0);
        end
      end
      prev = (o_play_sound === 1'b1);
    end
  endtask

  // Drive one request, hold it until accepted, and update the model.
  task automatic send(input logic [2:0] c);
    int n = 0;
    int fl;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_code  = c;
    #1;
    while (o_req_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("send_ready", int'(o_req_ready), 1);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    i_req_code  = 3'd0;
    if (c == 3'd7) begin
      // Head of the queue is the melody in progress; everything behind it is flushed.
      fl = (sb.size() > 0) ? sb.size() - 1 : 0;
      m_flush = (m_flush + fl > 255) ? 255 : m_flush + fl;
      while (sb.size() > 1) void'(sb.pop_back());
      if (sb.size() > 0) sb[0].len = 0;
      sb.push_back('{c, len_of(c)});
    end else if (c != 3'd0) begin
      sb.push_back('{c, len_of(c)});
    end
  endtask

  task automatic wait_play(input logic v, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_play_sound !== v && n < bound);
    chk("wait_play", int'(o_play_sound), int'(v));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy !== 1'b0 && n < bound);
    chk("wait_idle", int'(o_busy), 0);
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    i_req_valid = 1'b0;
    i_req_code = 3'd0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_code", int'(o_sound_code), 0);
    chk("rst_play", int'(o_play_sound), 0);
    chk("rst_rstn", int'(o_snd_rstn), 0);
    chk("rst_flush", int'(o_flush_cnt), 0);
    chk("rst_busy", int'(o_busy), 0);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_rstn_rise", int'(o_snd_rstn), 1);
    chk("rst_ready", int'(o_req_ready), 1);

    // 1: code 3 timing
    repeat (5) @(negedge clk);
    send(3'd3);
    @(negedge clk);
    chk("t1_idle_busy", int'(o_busy), 1);
    chk("t1_idle_rstn", int'(o_snd_rstn), 1);
    @(negedge clk);
    chk("t1_rst0_rstn", int'(o_snd_rstn), 0);
    chk("t1_rst0_code", int'(o_sound_code), 3);
    chk("t1_rst0_play", int'(o_play_sound), 0);
    @(negedge clk);
    chk("t1_rst1_rstn", int'(o_snd_rstn), 0);
    @(negedge clk);
    chk("t1_play", int'(o_play_sound), 1);
    chk("t1_play_rstn", int'(o_snd_rstn), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy !== 1'b0 && n < 1000);
    chk("t1_busy_drop", n, 195);

    // 2: code 1, code held through gap
    send(3'd1);
    wait_play(1'b1, 50);
    wait_play(1'b0, 400);
    chk("t2_gap_code0", int'(o_sound_code), 1);
    @(negedge clk);
    chk("t2_gap_code1", int'(o_sound_code), 1);
    @(negedge clk);
    chk("t2_gap_code2", int'(o_sound_code), 1);
    @(negedge clk);
    chk("t2_idle_busy", int'(o_busy), 0);

    // 3: fill FIFO during playback
    send(3'd2);
    wait_play(1'b1, 50);
    send(3'd2);
    send(3'd3);
    send(3'd4);
    send(3'd5);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_code = 3'd6;
    #1;
    chk("t3_full_refused", int'(o_req_ready), 0);
    send(3'd6);
    wait_idle(3000);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: preempt with code 7
    send(3'd4);
    wait_play(1'b1, 50);
    send(3'd1);
    send(3'd2);
    send(3'd3);
    repeat (10) @(negedge clk);
    send(3'd7);
    @(negedge clk);
    chk("t4_rstn", int'(o_snd_rstn), 0);
    chk("t4_code", int'(o_sound_code), 7);
    chk("t4_play", int'(o_play_sound), 0);
    chk("t4_flush", int'(o_flush_cnt), m_flush);
    wait_idle(1000);
    chk("t4_sb_empty", sb.size(), 0);

    // 5: code 0 is a no-op
    send(3'd0);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_busy !== 1'b0 || o_snd_rstn !== 1'b1) n++;
    end
    chk("t5_quiet", n, 0);

    // 6: reset mid-play
    send(3'd5);
    wait_play(1'b1, 50);
    repeat (20) @(negedge clk);
    i_rst = 1'b1;
    while (sb.size() > 1) void'(sb.pop_back());
    if (sb.size() > 0) sb[0].len = 0;
    m_flush = 0;
    @(negedge clk);
    chk("t6_play", int'(o_play_sound), 0);
    chk("t6_rstn", int'(o_snd_rstn), 0);
    chk("t6_code", int'(o_sound_code), 0);
    chk("t6_flush", int'(o_flush_cnt), m_flush);
    chk("t6_busy", int'(o_busy), 0);
    i_rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_after_busy", int'(o_busy), 0);
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
